// File: rtl/calc_sequencer_if.sv
// Key/ALU/display bundle between the calculator sequencer and its neighbours.
// master = environment (keypad, input unit, ALU); slave = calc_sequencer.
interface calc_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             key_valid;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] entry_value;
  logic             digit_accept;
  logic             entry_clear;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [1:0]       op;
  logic             alu_start;
  logic             alu_done;
  logic             alu_err;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic [1:0]       disp_sel;
  logic             busy;
  logic             error;

  modport master (
    output key_valid, key_code, entry_value, alu_done, alu_err, alu_result,
    input  digit_accept, entry_clear, operand_a, operand_b, op, alu_start,
           result, disp_sel, busy, error
  );

  modport slave (
    input  key_valid, key_code, entry_value, alu_done, alu_err, alu_result,
    output digit_accept, entry_clear, operand_a, operand_b, op, alu_start,
           result, disp_sel, busy, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Key-level calculator controller: digit gating, operand/operator latching, ALU handshake.
// Define CALC_CHAIN_EN to let an operator in SHOW_RESULT chain from the last result.
module calc_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MAX_DIGITS = 6,
  parameter int unsigned TIMEOUT    = 1024
) (
  input logic             clk,
  input logic             reset,
  calc_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] DispEntry  = 2'b00;
  localparam logic [1:0] DispResult = 2'b01;
  localparam logic [1:0] DispError  = 2'b10;

  typedef enum logic [2:0] {
    StEnterA,
    StEnterB,
    StExec,
    StWaitDone,
    StShowResult,
    StError
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [WIDTH-1:0] operand_a_q, operand_a_d;
  logic [WIDTH-1:0] operand_b_q, operand_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic             entry_clear_q, entry_clear_d;
  logic             digit_accept;

  logic       key_digit, key_oper, key_equals, key_clear, room;
  logic [1:0] key_op;

  always_comb begin
    key_digit  = bus.key_valid && (bus.key_code <= 4'd9);
    key_oper   = bus.key_valid && (bus.key_code >= 4'hA) && (bus.key_code <= 4'hD);
    key_equals = bus.key_valid && (bus.key_code == 4'hE);
    key_clear  = bus.key_valid && (bus.key_code == 4'hF);
    // A..D map to 00..11 by flipping bit 1 of the low pair.
    key_op     = bus.key_code[1:0] ^ 2'b10;
    room       = count_q < CntW'(MAX_DIGITS);
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    tmo_d         = '0;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    result_d      = result_q;
    op_d          = op_q;
    disp_sel_d    = disp_sel_q;
    entry_clear_d = 1'b0;
    digit_accept  = 1'b0;

    if (key_clear) begin
      state_d       = StEnterA;
      count_d       = '0;
      operand_a_d   = '0;
      operand_b_d   = '0;
      result_d      = '0;
      op_d          = 2'b00;
      disp_sel_d    = DispEntry;
      entry_clear_d = 1'b1;
    end else begin
      unique case (state_q)
        StEnterA: begin
          if (key_digit) begin
            if (room) begin
              digit_accept = 1'b1;
              count_d      = count_q + CntW'(1);
            end
          end else if (key_oper) begin
            operand_a_d   = bus.entry_value;
            op_d          = key_op;
            count_d       = '0;
            entry_clear_d = 1'b1;
            state_d       = StEnterB;
          end
        end
        StEnterB: begin
          if (key_digit) begin
            if (room) begin
              digit_accept = 1'b1;
              count_d      = count_q + CntW'(1);
            end
          end else if (key_oper) begin
            // Operator can be changed only before any digit of B is typed.
            if (count_q == '0) op_d = key_op;
          end else if (key_equals) begin
            operand_b_d = (count_q == '0) ? '0 : bus.entry_value;
            state_d     = StExec;
          end
        end
        StExec: begin
          state_d = StWaitDone;
        end
        StWaitDone: begin
          tmo_d = tmo_q + TmoW'(1);
          if (bus.alu_done) begin
            if (bus.alu_err) begin
              disp_sel_d = DispError;
              state_d    = StError;
            end else begin
              result_d      = bus.alu_result;
              disp_sel_d    = DispResult;
              entry_clear_d = 1'b1;
              state_d       = StShowResult;
            end
          end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
            disp_sel_d = DispError;
            state_d    = StError;
          end
        end
        StShowResult: begin
          if (key_digit) begin
            // The same key becomes the first digit of a fresh operand A.
            digit_accept = 1'b1;
            count_d      = CntW'(1);
            disp_sel_d   = DispEntry;
            state_d      = StEnterA;
          end
`ifdef CALC_CHAIN_EN
          else if (key_oper) begin
            operand_a_d = result_q;
            op_d        = key_op;
            count_d     = '0;
            disp_sel_d  = DispEntry;
            state_d     = StEnterB;
          end
`endif
        end
        StError: begin
          state_d = StError;
        end
        default: begin
          state_d = StEnterA;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StEnterA;
      count_q       <= '0;
      tmo_q         <= '0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      result_q      <= '0;
      op_q          <= 2'b00;
      disp_sel_q    <= DispEntry;
      entry_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      tmo_q         <= tmo_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      result_q      <= result_d;
      op_q          <= op_d;
      disp_sel_q    <= disp_sel_d;
      entry_clear_q <= entry_clear_d;
    end
  end

  assign bus.digit_accept = digit_accept;
  assign bus.entry_clear  = entry_clear_q;
  assign bus.operand_a    = operand_a_q;
  assign bus.operand_b    = operand_b_q;
  assign bus.op           = op_q;
  assign bus.result       = result_q;
  assign bus.disp_sel     = disp_sel_q;
  assign bus.alu_start    = (state_q == StExec);
  assign bus.busy         = (state_q == StExec) || (state_q == StWaitDone);
  assign bus.error        = (state_q == StError);

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: vector tables, an operand scoreboard and
// hand-written sequences for timeout, abort, error and chaining (CALC_CHAIN_EN aware).
module tb_calc_sequencer;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_sequencer_if #(.WIDTH(W)) bus ();

  calc_sequencer #(
    .WIDTH     (W),
    .MAX_DIGITS(6),
    .TIMEOUT   (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
  } sb_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   key;
  } vec_t;

  typedef struct {
    logic [3:0] key;
    logic       acc;
  } dig_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    check(name, {{(W-1){1'b0}}, act}, {{(W-1){1'b0}}, exp});
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    check(name, {{(W-2){1'b0}}, act}, {{(W-2){1'b0}}, exp});
  endtask

  function automatic logic [1:0] key_to_op(input logic [3:0] k);
    case (k)
      4'hA:    return 2'd0;
      4'hB:    return 2'd1;
      4'hC:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [W-1:0] alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (b == '0) ? '0 : W'(sa / sb);
    endcase
  endfunction

  task automatic press(input logic [3:0] key, input logic [W-1:0] ev, output logic acc);
    @(negedge clk);
    bus.key_valid   = 1'b1;
    bus.key_code    = key;
    bus.entry_value = ev;
    #1 acc = bus.digit_accept;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Called right after the equals key; pops the expected operands when the start pulse shows.
  task automatic take_start(input string tag);
    sb_t e;
    chkb({tag, " alu_start"}, bus.alu_start, 1'b1);
    if (bus.alu_start && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, " operand_a"}, bus.operand_a, e.a);
      check({tag, " operand_b"}, bus.operand_b, e.b);
      chk2({tag, " op"}, bus.op, e.op);
    end
    @(negedge clk);
    chkb({tag, " start single pulse"}, bus.alu_start, 1'b0);
    chkb({tag, " busy in wait"}, bus.busy, 1'b1);
  endtask

  task automatic respond(input int delay, input logic [W-1:0] res, input logic err);
    repeat (delay) @(negedge clk);
    bus.alu_done   = 1'b1;
    bus.alu_result = res;
    bus.alu_err    = err;
    @(negedge clk);
    bus.alu_done = 1'b0;
    bus.alu_err  = 1'b0;
  endtask

  task automatic enter_op(input logic [W-1:0] a, input logic [3:0] key, input logic [W-1:0] b);
    logic acc;
    press(4'hF, '0, acc);
    press(4'd1, a, acc);
    press(key, a, acc);
    press(4'd2, b, acc);
    sb_q.push_back('{a: a, b: b, op: key_to_op(key)});
    press(4'hE, b, acc);
  endtask

  initial begin
    logic         acc;
    int           ec;
    logic [W-1:0] exp_res;
    logic         exp_err;
    vec_t         vec[5];
    dig_t         dig[8];

    vec[0] = '{a: 32'd12,  b: 32'd3,          key: 4'hA};
    vec[1] = '{a: 32'd100, b: 32'hFFFF_FFF9,  key: 4'hB};
    vec[2] = '{a: 32'd6,   b: 32'd7,          key: 4'hC};
    vec[3] = '{a: 32'hFFFF_FFEC, b: 32'd4,    key: 4'hD};
    vec[4] = '{a: 32'd5,   b: 32'd0,          key: 4'hD};
    for (int i = 0; i < 8; i++) dig[i] = '{key: 4'(i + 1), acc: (i < 6)};

    bus.key_valid   = 1'b0;
    bus.key_code    = 4'h0;
    bus.entry_value = '0;
    bus.alu_done    = 1'b0;
    bus.alu_err     = 1'b0;
    bus.alu_result  = '0;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    check("reset operand_a", bus.operand_a, '0);
    check("reset operand_b", bus.operand_b, '0);
    check("reset result", bus.result, '0);
    chk2("reset op", bus.op, 2'b00);
    chk2("reset disp_sel", bus.disp_sel, 2'b00);
    chkb("reset alu_start", bus.alu_start, 1'b0);
    chkb("reset entry_clear", bus.entry_clear, 1'b0);
    chkb("reset busy", bus.busy, 1'b0);
    chkb("reset error", bus.error, 1'b0);
    reset = 1'b0;

    // 12 + 3 with a multi-digit operand A
    press(4'd1, 32'd1, acc);
    chkb("t1 digit1 accept", acc, 1'b1);
    press(4'd2, 32'd12, acc);
    chkb("t1 digit2 accept", acc, 1'b1);
    press(4'hA, 32'd12, acc);
    chkb("t1 op accept", acc, 1'b0);
    chkb("t1 entry_clear on op", bus.entry_clear, 1'b1);
    check("t1 operand_a latched", bus.operand_a, 32'd12);
    press(4'd3, 32'd3, acc);
    sb_q.push_back('{a: 32'd12, b: 32'd3, op: 2'd0});
    press(4'hE, 32'd3, acc);
    take_start("t1");
    respond(4, 32'd15, 1'b0);
    check("t1 result", bus.result, 32'd15);
    chk2("t1 disp_sel", bus.disp_sel, 2'b01);
    chkb("t1 entry_clear on done", bus.entry_clear, 1'b1);
    chkb("t1 busy after done", bus.busy, 1'b0);

    // Digit limit
    press(4'hF, '0, acc);
    for (int i = 0; i < 8; i++) begin
      press(dig[i].key, W'(i + 1), acc);
      chkb($sformatf("digit %0d accept", i + 1), acc, dig[i].acc);
    end
    press(4'hA, 32'd123456, acc);
    check("digit limit then op", bus.operand_a, 32'd123456);

    // Operation table through the scoreboard
    for (int i = 0; i < 5; i++) begin
      enter_op(vec[i].a, vec[i].key, vec[i].b);
      take_start($sformatf("vec%0d", i));
      exp_err = (vec[i].key == 4'hD) && (vec[i].b == '0);
      exp_res = alu_model(vec[i].a, vec[i].b, key_to_op(vec[i].key));
      respond(3, exp_err ? 32'hDEAD : exp_res, exp_err);
      if (exp_err) begin
        chkb($sformatf("vec%0d error", i), bus.error, 1'b1);
        check($sformatf("vec%0d result kept", i), bus.result, '0);
      end else begin
        check($sformatf("vec%0d result", i), bus.result, exp_res);
        chk2($sformatf("vec%0d disp_sel", i), bus.disp_sel, 2'b01);
      end
    end

    // 9 / 0 error path
    press(4'hF, '0, acc);
    press(4'd9, 32'd9, acc);
    press(4'hD, 32'd9, acc);
    press(4'd0, 32'd0, acc);
    sb_q.push_back('{a: 32'd9, b: 32'd0, op: 2'd3});
    press(4'hE, 32'd0, acc);
    take_start("t3");
    respond(2, 32'hDEAD, 1'b1);
    chkb("t3 error", bus.error, 1'b1);
    chk2("t3 disp_sel", bus.disp_sel, 2'b10);
    press(4'd5, 32'd5, acc);
    chkb("t3 digit ignored", acc, 1'b0);
    chkb("t3 still error", bus.error, 1'b1);
    press(4'hF, '0, acc);
    chkb("t3 clear error", bus.error, 1'b0);
    chkb("t3 clear entry_clear", bus.entry_clear, 1'b1);
    check("t3 clear operand_a", bus.operand_a, '0);
    check("t3 clear operand_b", bus.operand_b, '0);
    chk2("t3 clear op", bus.op, 2'b00);
    chk2("t3 clear disp_sel", bus.disp_sel, 2'b00);

    // Timeout without done
    enter_op(32'd1, 4'hA, 32'd2);
    take_start("t4a");
    repeat (7) @(negedge clk);
    chkb("t4a no error in 8th wait cycle", bus.error, 1'b0);
    @(negedge clk);
    chkb("t4a error after timeout", bus.error, 1'b1);
    chk2("t4a disp_sel", bus.disp_sel, 2'b10);

    // Done coincident with expiry wins
    enter_op(32'd1, 4'hA, 32'd2);
    take_start("t4b");
    repeat (7) @(negedge clk);
    bus.alu_done   = 1'b1;
    bus.alu_result = 32'd3;
    @(negedge clk);
    bus.alu_done = 1'b0;
    chkb("t4b no error", bus.error, 1'b0);
    chk2("t4b disp_sel", bus.disp_sel, 2'b01);
    check("t4b result", bus.result, 32'd3);

    // Clear aborts WAIT_DONE; late done ignored
    enter_op(32'd1, 4'hA, 32'd2);
    take_start("t5");
    press(4'hF, '0, acc);
    ec = int'(bus.entry_clear);
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        bus.alu_done   = 1'b1;
        bus.alu_result = 32'h77;
      end
      @(negedge clk);
      bus.alu_done = 1'b0;
      ec += int'(bus.entry_clear);
    end
    check("t5 entry_clear pulses", W'(ec), 32'd1);
    check("t5 result unchanged", bus.result, '0);
    chk2("t5 disp_sel", bus.disp_sel, 2'b00);
    chkb("t5 not busy", bus.busy, 1'b0);
    press(4'd4, 32'd4, acc);
    chkb("t5 back in entry", acc, 1'b1);

    // Reset mid-operation
    enter_op(32'd1, 4'hA, 32'd2);
    take_start("trst");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chkb("mid reset busy", bus.busy, 1'b0);
    check("mid reset operand_a", bus.operand_a, '0);

    // Operator overwrite in ENTER_B only while no digit typed; empty B equals 0
    press(4'hF, '0, acc);
    press(4'd4, 32'd4, acc);
    press(4'hA, 32'd4, acc);
    press(4'hB, 32'd4, acc);
    chk2("overwrite op B", bus.op, 2'd1);
    press(4'hC, 32'd4, acc);
    chk2("overwrite op C", bus.op, 2'd2);
    press(4'd5, 32'd5, acc);
    press(4'hD, 32'd5, acc);
    chk2("op locked after digit", bus.op, 2'd2);
    sb_q.push_back('{a: 32'd4, b: 32'd5, op: 2'd2});
    press(4'hE, 32'd5, acc);
    take_start("tovw");
    respond(1, alu_model(32'd4, 32'd5, 2'd2), 1'b0);
    check("overwrite result", bus.result, 32'd20);
    press(4'hF, '0, acc);
    press(4'd7, 32'd7, acc);
    press(4'hA, 32'd7, acc);
    sb_q.push_back('{a: 32'd7, b: 32'd0, op: 2'd0});
    press(4'hE, 32'd99, acc);
    take_start("tempty");
    respond(1, 32'd7, 1'b0);

    // 2 + 3 =, then C 4 =
    press(4'hF, '0, acc);
    press(4'd2, 32'd2, acc);
    press(4'hA, 32'd2, acc);
    press(4'd3, 32'd3, acc);
    sb_q.push_back('{a: 32'd2, b: 32'd3, op: 2'd0});
    press(4'hE, 32'd3, acc);
    take_start("t6");
    respond(2, 32'd5, 1'b0);
    check("t6 first result", bus.result, 32'd5);
    press(4'hC, '0, acc);
    chkb("t6 op not a digit", acc, 1'b0);
`ifdef CALC_CHAIN_EN
    check("t6 chain operand_a", bus.operand_a, 32'd5);
    chk2("t6 chain op", bus.op, 2'd2);
    chk2("t6 chain disp_sel", bus.disp_sel, 2'b00);
    press(4'd4, 32'd4, acc);
    chkb("t6 chain digit", acc, 1'b1);
    sb_q.push_back('{a: 32'd5, b: 32'd4, op: 2'd2});
    press(4'hE, 32'd4, acc);
    take_start("t6c");
    respond(2, alu_model(32'd5, 32'd4, 2'd2), 1'b0);
    check("t6 chain result", bus.result, 32'd20);
`else
    chk2("t6 op ignored disp_sel", bus.disp_sel, 2'b01);
    chk2("t6 op ignored op", bus.op, 2'd0);
    press(4'd4, 32'd4, acc);
    chkb("t6 digit restarts", acc, 1'b1);
    chk2("t6 digit disp_sel", bus.disp_sel, 2'b00);
    press(4'hA, 32'd4, acc);
    check("t6 new operand_a", bus.operand_a, 32'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
